// File: rtl/gpu_pkg.sv
// Shared encodings and default widths for the scheduler, fetcher and decoder.
package gpu_pkg;

    localparam int ADDR_BITS_DEFAULT = 8;
    localparam int DATA_BITS_DEFAULT = 16;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

    function automatic bit is_pow2_min2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetcher_if.sv
// Program-memory read port: valid/ready request with returned instruction word.
interface fetcher_if #(
    parameter int ADDR_BITS = gpu_pkg::ADDR_BITS_DEFAULT,
    parameter int DATA_BITS = gpu_pkg::DATA_BITS_DEFAULT
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/fetcher_icache.sv
// Direct-mapped read-only instruction cache; combinational lookup, fill on the capture edge.
module fetcher_icache
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEFAULT,
    parameter int DATA_BITS = DATA_BITS_DEFAULT,
    parameter int ENTRIES   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] lookup_pc,
    output logic                 hit,
    output logic [DATA_BITS-1:0] hit_data,
    input  logic                 fill_en,
    input  logic [ADDR_BITS-1:0] fill_pc,
    input  logic [DATA_BITS-1:0] fill_data
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [ENTRIES-1:0]  line_valid;
    logic [TAG_BITS-1:0] line_tag  [ENTRIES];
    logic [DATA_BITS-1:0] line_data [ENTRIES];

    logic [IDX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0] lookup_tag;
    logic [IDX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0] fill_tag;

    assign lookup_idx = lookup_pc[IDX_BITS-1:0];
    assign lookup_tag = lookup_pc[ADDR_BITS-1:IDX_BITS];
    assign fill_idx   = fill_pc[IDX_BITS-1:0];
    assign fill_tag   = fill_pc[ADDR_BITS-1:IDX_BITS];

    assign hit      = line_valid[lookup_idx] && (line_tag[lookup_idx] == lookup_tag);
    assign hit_data = line_data[lookup_idx];

    // Only the valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_valid <= '0;
        end else if (fill_en) begin
            line_valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= fill_data;
        end
    end
endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage between scheduler and program memory.
// Optional direct-mapped instruction cache compiled in with FETCHER_ICACHE_EN.
//
// state    | meaning
// IDLE     | no request outstanding, waiting for core_state==FETCH
// FETCHING | request held on the memory port until mem_read_ready
// FETCHED  | instruction latched, waiting for core_state==DECODE
module fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = ADDR_BITS_DEFAULT,
    parameter int PROGRAM_MEM_DATA_BITS = DATA_BITS_DEFAULT,
    parameter int ICACHE_ENTRIES        = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    fetcher_if.master                        mem,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);
    if (!is_pow2_min2(ICACHE_ENTRIES)) begin : g_bad_entries
        $error("ICACHE_ENTRIES must be a power of two and at least 2");
    end

    fetcher_state_t                   state;
    logic                             req_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_addr;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q;
    logic                             capture;
    logic                             cache_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;

    assign capture = (state == FETCHER_FETCHING) && req_valid && mem.mem_read_ready;

`ifdef FETCHER_ICACHE_EN
    fetcher_icache #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .ENTRIES   (ICACHE_ENTRIES)
    ) u_icache (
        .clk       (clk),
        .reset     (reset),
        .lookup_pc (current_pc),
        .hit       (cache_hit),
        .hit_data  (cache_data),
        .fill_en   (capture),
        .fill_pc   (req_addr),
        .fill_data (mem.mem_read_data)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCHER_IDLE;
            req_valid <= 1'b0;
            req_addr  <= '0;
            instr_q   <= '0;
        end else begin
            case (state)
                FETCHER_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (cache_hit) begin
                            state   <= FETCHER_FETCHED;
                            instr_q <= cache_data;
                        end else begin
                            state     <= FETCHER_FETCHING;
                            req_valid <= 1'b1;
                            req_addr  <= current_pc;
                        end
                    end
                end
                // Request is never withdrawn, even if the scheduler leaves FETCH.
                FETCHER_FETCHING: begin
                    if (capture) begin
                        state     <= FETCHER_FETCHED;
                        req_valid <= 1'b0;
                        instr_q   <= mem.mem_read_data;
                    end
                end
                FETCHER_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state <= FETCHER_IDLE;
                    end
                end
                default: begin
                    state     <= FETCHER_IDLE;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_read_valid   = req_valid;
    assign mem.mem_read_address = req_addr;
    assign fetcher_state        = state;
    assign instruction          = instr_q;
endmodule

// File: tb/tb_fetcher.sv
// Directed table-driven bench for fetcher, plus reset/idle/done corner sequences.
module tb_fetcher;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  core_state = CORE_IDLE;
    logic [7:0]  current_pc = '0;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    int total = 0;
    int bad = 0;

    fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) mem_bus ();

    fetcher #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16),
        .ICACHE_ENTRIES        (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .mem           (mem_bus.master),
        .fetcher_state (fetcher_state),
        .instruction   (instruction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] data;
        int          stall;
        int          exp_edges;
        int          exp_reqs;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   edges;
        int   reqs;
        int   vcnt;
        logic prev_valid;
        logic addr_ok;
        bit   done;
        v = vecs[i];
        edges = 0; reqs = 0; vcnt = 0; prev_valid = 1'b0; addr_ok = 1'b1; done = 1'b0;
        @(posedge clk);
        #1;
        core_state = CORE_FETCH;
        current_pc = v.pc;
        mem_bus.mem_read_data  = v.data;
        mem_bus.mem_read_ready = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_bus.mem_read_valid) begin
                vcnt++;
                if (mem_bus.mem_read_address !== v.pc) addr_ok = 1'b0;
                if (!prev_valid) reqs++;
            end
            prev_valid = mem_bus.mem_read_valid;
            mem_bus.mem_read_ready = mem_bus.mem_read_valid && (vcnt > v.stall);
            @(posedge clk);
            edges++;
            #1;
            if (fetcher_state == FETCHER_FETCHED) done = 1'b1;
        end
        if (!done) check($sformatf("timeout[%0d]", i), 32'(fetcher_state), 32'(FETCHER_FETCHED));
        check($sformatf("edges[%0d]", i), 32'(edges), 32'(v.exp_edges));
        check($sformatf("reqs[%0d]", i), 32'(reqs), 32'(v.exp_reqs));
        if (v.exp_reqs > 0)
            check($sformatf("valid_cycles[%0d]", i), 32'(vcnt), 32'(v.stall + 1));
        check($sformatf("addr_stable[%0d]", i), 32'(addr_ok), 32'd1);
        check($sformatf("instr[%0d]", i), 32'(instruction), 32'(v.exp_instr));
        check($sformatf("valid_after[%0d]", i), 32'(mem_bus.mem_read_valid), 32'd0);
        mem_bus.mem_read_ready = 1'b0;
        core_state = CORE_EXECUTE;
        @(posedge clk);
        #1;
        check($sformatf("hold_fetched[%0d]", i), 32'(fetcher_state), 32'(FETCHER_FETCHED));
        core_state = CORE_DECODE;
        @(posedge clk);
        #1;
        check($sformatf("back_idle[%0d]", i), 32'(fetcher_state), 32'(FETCHER_IDLE));
        check($sformatf("instr_held[%0d]", i), 32'(instruction), 32'(v.exp_instr));
        core_state = CORE_IDLE;
    endtask

    initial begin
        mem_bus.mem_read_ready = 1'b0;
        mem_bus.mem_read_data  = '0;

        vecs[0] = '{8'h05, 16'h3A12, 0, 2, 1, 16'h3A12};
        vecs[1] = '{8'h10, 16'h1234, 4, 6, 1, 16'h1234};
        vecs[2] = '{8'hFF, 16'hBEEF, 0, 2, 1, 16'hBEEF};
        vecs[3] = '{8'h00, 16'h0001, 1, 3, 1, 16'h0001};
        vecs[4] = '{8'h03, 16'h0303, 0, 2, 1, 16'h0303};
`ifdef FETCHER_ICACHE_EN
        vecs[5] = '{8'h03, 16'hDEAD, 0, 1, 0, 16'h0303};
`else
        vecs[5] = '{8'h03, 16'hDEAD, 0, 2, 1, 16'hDEAD};
`endif
        vecs[6] = '{8'h0B, 16'h0B0B, 0, 2, 1, 16'h0B0B};
        vecs[7] = '{8'h03, 16'h3333, 0, 2, 1, 16'h3333};

        #3;
        check("rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        check("rst_valid", 32'(mem_bus.mem_read_valid), 32'd0);
        check("rst_addr", 32'(mem_bus.mem_read_address), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Ready pulses while idle must be ignored.
        @(negedge clk);
        core_state = CORE_IDLE;
        mem_bus.mem_read_data  = 16'hFFFF;
        mem_bus.mem_read_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_bus.mem_read_ready = 1'b0;
        check("idle_ready_instr", 32'(instruction), 32'h3333);
        check("idle_ready_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        check("idle_ready_valid", 32'(mem_bus.mem_read_valid), 32'd0);

        // DONE never issues a request.
        core_state = CORE_DONE;
        repeat (3) @(posedge clk);
        #1;
        check("done_valid", 32'(mem_bus.mem_read_valid), 32'd0);
        check("done_state", 32'(fetcher_state), 32'(FETCHER_IDLE));

        // Request survives the scheduler leaving FETCH; async reset drops it at once.
        core_state = CORE_FETCH;
        current_pc = 8'h20;
        @(posedge clk);
        #1;
        check("mid_valid", 32'(mem_bus.mem_read_valid), 32'd1);
        check("mid_addr", 32'(mem_bus.mem_read_address), 32'h20);
        core_state = CORE_WAIT;
        @(posedge clk);
        #1;
        check("no_withdraw_valid", 32'(mem_bus.mem_read_valid), 32'd1);
        check("no_withdraw_state", 32'(fetcher_state), 32'(FETCHER_FETCHING));
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(mem_bus.mem_read_valid), 32'd0);
        check("async_rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        check("async_rst_instr", 32'(instruction), 32'd0);
        core_state = CORE_IDLE;
        mem_bus.mem_read_ready = 1'b1;
        mem_bus.mem_read_data  = 16'hA5A5;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", 32'(mem_bus.mem_read_valid), 32'd0);
        check("post_rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        check("post_rst_instr", 32'(instruction), 32'd0);
        mem_bus.mem_read_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetcher.md
Name: fetcher

Overview:
- Instruction fetch stage of a core. Sits between the scheduler and program memory.
- When the scheduler's core_state enters FETCH, the block reads the instruction at current_pc over a valid/ready program-memory port.
- It latches the instruction for the decoder and reports fetcher_state back to the scheduler, which leaves FETCH only when fetcher_state is FETCHED.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, width of current_pc and mem_read_address.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.
- ICACHE_ENTRIES, 8, number of instruction-cache lines; power of 2, at least 2. Used only with FETCHER_ICACHE_EN.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- core_state  in  3  scheduler state. IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- current_pc  in  PROGRAM_MEM_ADDR_BITS  address to fetch; stable while core_state==FETCH.
- mem_read_valid  out  1  program-memory read request.
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  read address.
- mem_read_ready  in  1  memory returns data this cycle.
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  returned instruction.
- fetcher_state  out  3  IDLE=000, FETCHING=001, FETCHED=010; other codes unused.
- instruction  out  PROGRAM_MEM_DATA_BITS  latched instruction for the decoder.

Behaviour:
- Reset (reset==0, asynchronous, takes effect immediately):
  - fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0.
  - All cache valid bits cleared.
  - Reset mid-transaction drops mem_read_valid at once. The in-flight response is not tracked; a mem_read_ready arriving after release is ignored unless a new request is outstanding.
- IDLE:
  - If core_state==FETCH: next cycle fetcher_state=FETCHING, mem_read_valid=1, mem_read_address=current_pc.
  - Otherwise hold.
- FETCHING:
  - mem_read_valid and mem_read_address stay stable until the cycle mem_read_ready==1.
  - On that edge: instruction<=mem_read_data, mem_read_valid<=0, fetcher_state<=FETCHED.
  - A request is never withdrawn: if core_state leaves FETCH meanwhile, the block still waits for ready.
- FETCHED:
  - instruction holds.
  - When core_state==DECODE: fetcher_state<=IDLE next cycle. Otherwise stay in FETCHED.
  - instruction holds its value until the next completed fetch, so it stays valid through DECODE..UPDATE.
- mem_read_ready is ignored whenever mem_read_valid==0.
- Latency with a zero-wait memory (ready in the first valid cycle):
  - FETCH seen at edge N; request at N+1; FETCHED at N+2.
  - The scheduler moves to DECODE at N+3; the fetcher returns to IDLE at N+4.
- core_state==DONE or IDLE: the block stays idle and issues no requests.
- PC wrap: addresses are used as-is, modulo 2^PROGRAM_MEM_ADDR_BITS; there is no special handling at 0xFF.

Optional Feature:
- Macro FETCHER_ICACHE_EN compiles in a direct-mapped, read-only instruction cache.
- Cache organisation:
  - ICACHE_ENTRIES lines, each holding a valid bit, a tag and an instruction.
  - index = low log2(ICACHE_ENTRIES) bits of current_pc; tag = remaining pc bits.
- Hit in IDLE with core_state==FETCH: next cycle fetcher_state=FETCHED and instruction=cached word. No memory request is issued (mem_read_valid stays 0).
- Miss: normal FETCHING sequence; on the ready edge the line is filled (valid=1, tag, data) in the same edge that instruction is captured.
- Conflicting pcs evict each other.
- Lines are invalidated only by reset.
- Without the macro: no cache storage; every fetch goes to memory. Port list is identical in both builds.

Decomposition:
- Package gpu_pkg holds the core_state encodings (IDLE..DONE), the fetcher_state encodings (IDLE/FETCHING/FETCHED), and default address/data widths, shared with the scheduler and decoder.
- Sub-module fetcher_icache (lookup: hit/data; fill port) is instantiated only under FETCHER_ICACHE_EN.

Test Plan:
- Reset with reset=0 mid-FETCHING, valid=1 → same cycle: valid=0, state=IDLE, instruction=0. After release with core_state=IDLE → no request.
- core_state=FETCH, pc=0x05, ready on the first valid cycle, data=0x3A12 → address=0x05; FETCHED two edges after FETCH; instruction=0x3A12; IDLE one edge after core_state=DECODE.
- Memory stalls ready for 4 cycles, pc=0x10 → valid and address=0x10 stable for all 5 cycles; a single capture of data; exactly one request.
- ready pulsed while idle, data=0xFFFF → instruction unchanged and fetcher_state stays IDLE.
- FETCHER_ICACHE_EN, ICACHE_ENTRIES=8:
  - Fetch pc=0x03 twice → the second fetch issues no request and reaches FETCHED one edge after FETCH with the same instruction.
  - Then fetch pc=0x0B (same index, new tag) → miss, memory request issued.
  - Then fetch pc=0x03 again → miss, memory request issued (line was evicted).
- Fetch pc=0xFF, then pc=0x00 → both addresses driven correctly; no wrap artefacts.
